// File: rtl/ni_packet_tx.sv
// Network-interface packetizer: wraps a core message into HEAD/BODY/TAIL ring flits.
// Optional TX_CHECKSUM_EN adds a body XOR checksum and flit count to the TAIL.
module ni_packet_tx #(
  parameter logic [1:0]  NODE_ID = 2'b00,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [1:0]  msg_dest,
  input  logic [5:0]  msg_len,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_in,
  input  logic        full,
  input  logic        do_not_send,
  output logic [47:0] flit_out,
  output logic        flit_valid,
  output logic        busy,
  output logic        pkt_sent
);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

  localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

  state_t      state, state_next;
  logic [1:0]  dest_q;
  logic [5:0]  len_q;
  logic [5:0]  count_q;
  logic        slot_tail;
  logic        accept;
  logic        slot_free;
  logic        hdr_take;
  logic        load_head, load_body, load_tail;
  logic [5:0]  len_clamped;
  logic [47:0] head_flit, body_flit, tail_flit;

  assign accept      = flit_valid & ~full & ~do_not_send;
  assign slot_free   = ~flit_valid | accept;
  assign busy        = (state != IDLE) | flit_valid;
  assign hdr_take    = msg_valid & msg_ready;
  assign len_clamped = (msg_len > MAX_LEN6) ? MAX_LEN6 : msg_len;
  assign body_flit   = {8'h00, 2'b00, count_q, data_in};

`ifdef TX_CHECKSUM_EN
  logic [7:0] csum_q;

  assign head_flit = {6'b101111, dest_q, NODE_ID, len_q, 1'b1, 31'd0};
  // count_q equals the number of body flits at the moment TAIL is loaded
  assign tail_flit = {8'hFF, csum_q, 26'd0, count_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else if (load_head) begin
      csum_q <= '0;
    end else if (load_body) begin
      csum_q <= csum_q ^ data_in[31:24] ^ data_in[23:16] ^ data_in[15:8] ^ data_in[7:0];
    end
  end
`else
  assign head_flit = {6'b101111, dest_q, NODE_ID, len_q, 32'd0};
  assign tail_flit = {8'hFF, 40'd0};
`endif

  always_comb begin
    state_next = state;
    msg_ready  = 1'b0;
    data_ready = 1'b0;
    load_head  = 1'b0;
    load_body  = 1'b0;
    load_tail  = 1'b0;
    case (state)
      IDLE: begin
        msg_ready = rst & slot_free;
        if (msg_valid & msg_ready) state_next = HEAD;
      end
      HEAD: begin
        if (slot_free) begin
          load_head  = 1'b1;
          state_next = (len_q != 6'd0) ? BODY : TAIL;
        end
      end
      BODY: begin
        data_ready = rst & slot_free;
        if (data_valid & data_ready) begin
          load_body = 1'b1;
          if (count_q + 6'd1 == len_q) state_next = TAIL;
        end
      end
      TAIL: begin
        if (slot_free) begin
          load_tail  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flit_out   <= '0;
      flit_valid <= 1'b0;
      pkt_sent   <= 1'b0;
      count_q    <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      slot_tail  <= 1'b0;
    end else begin
      state    <= state_next;
      pkt_sent <= accept & slot_tail;
      if (hdr_take) begin
        dest_q <= msg_dest;
        len_q  <= len_clamped;
      end
      if (load_head) begin
        flit_out   <= head_flit;
        flit_valid <= 1'b1;
        slot_tail  <= 1'b0;
      end else if (load_body) begin
        flit_out   <= body_flit;
        flit_valid <= 1'b1;
        slot_tail  <= 1'b0;
        count_q    <= count_q + 6'd1;
      end else if (load_tail) begin
        flit_out   <= tail_flit;
        flit_valid <= 1'b1;
        slot_tail  <= 1'b1;
        count_q    <= '0;
      end else if (accept) begin
        flit_valid <= 1'b0;
        slot_tail  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ni_packet_tx.sv
// Directed self-checking bench for ni_packet_tx (NODE_ID=0, MAX_LEN=4).
`timescale 1ns/1ps
module tb_ni_packet_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid, msg_ready;
  logic [1:0]  msg_dest;
  logic [5:0]  msg_len;
  logic        data_valid, data_ready;
  logic [31:0] data_in;
  logic        full, do_not_send;
  logic [47:0] flit_out;
  logic        flit_valid, busy, pkt_sent;

  always #5 clk = ~clk;

  ni_packet_tx #(.NODE_ID(2'b00), .MAX_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_dest(msg_dest), .msg_len(msg_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .full(full), .do_not_send(do_not_send),
    .flit_out(flit_out), .flit_valid(flit_valid), .busy(busy), .pkt_sent(pkt_sent)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int consumed = 0;
  int dr_seen = 0;
  logic [47:0] got[$];
  int got_cyc[$];
  int sent_cyc[$];
  int hdr_cyc[$];
  logic [31:0] words [8];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (flit_valid && !full && !do_not_send) begin
      got.push_back(flit_out);
      got_cyc.push_back(cyc);
    end
    if (pkt_sent) sent_cyc.push_back(cyc);
    if (data_valid && data_ready) consumed++;
    if (data_ready) dr_seen++;
    if (msg_valid && msg_ready) hdr_cyc.push_back(cyc);
  end

  function automatic logic [47:0] head_f(input logic [1:0] d, input logic [5:0] l);
    logic [47:0] f;
    f = {6'b101111, d, 2'b00, l, 32'd0};
`ifdef TX_CHECKSUM_EN
    f[31] = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [47:0] body_f(input logic [5:0] s, input logic [31:0] w);
    return {8'h00, 2'b00, s, w};
  endfunction

  function automatic logic [47:0] tail_f(input int n);
`ifdef TX_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++)
      x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    return {8'hFF, x, 26'd0, 6'(n)};
`else
    return {8'hFF, 40'd0};
`endif
  endfunction

  task automatic clear_logs();
    got.delete(); got_cyc.delete(); sent_cyc.delete(); hdr_cyc.delete();
  endtask

  task automatic drive_packet(input logic [1:0] d, input logic [5:0] l, input int nw, output bit ok);
    bit r;
    int k;
    ok = 1'b1;
    msg_valid = 1'b1; msg_dest = d; msg_len = l;
    k = 0;
    do begin @(negedge clk); r = msg_ready; @(posedge clk); #1; k++; end while (!r && k < 100);
    msg_valid = 1'b0;
    if (!r) ok = 1'b0;
    for (int i = 0; i < nw; i++) begin
      data_valid = 1'b1; data_in = words[i];
      k = 0;
      do begin @(negedge clk); r = data_ready; @(posedge clk); #1; k++; end while (!r && k < 100);
      if (!r) ok = 1'b0;
    end
    data_valid = 1'b0; data_in = '0;
  endtask

  task automatic wait_flits(input int n, output bit ok);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin @(posedge clk); k++; end
    repeat (3) @(posedge clk);
    #1;
    ok = (got.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0; msg_valid = 1'b1; data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (flit_out !== 48'd0) begin errors++; $display("FAIL rst_flit_out got %h want 0", flit_out); end
      checks++; if (flit_valid !== 1'b0) begin errors++; $display("FAIL rst_flit_valid got %b want 0", flit_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (pkt_sent !== 1'b0) begin errors++; $display("FAIL rst_pkt_sent got %b want 0", pkt_sent); end
      checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL rst_msg_ready got %b want 0", msg_ready); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready got %b want 0", data_ready); end
    end
    @(posedge clk); #1;
    rst = 1'b1; msg_valid = 1'b0; data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++; if (flit_valid !== 1'b0 || busy !== 1'b0 || pkt_sent !== 1'b0 || flit_out !== 48'd0)
        begin errors++; $display("FAIL idle_outputs got v=%b b=%b p=%b f=%h want 0", flit_valid, busy, pkt_sent, flit_out); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok1, ok2;
    logic [47:0] exp [4];
    clear_logs();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
    exp[0] = head_f(2'd2, 6'd2); exp[1] = body_f(6'd0, words[0]);
    exp[2] = body_f(6'd1, words[1]); exp[3] = tail_f(2);
    drive_packet(2'd2, 6'd2, 2, ok1);
    wait_flits(4, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL basic_timeout got %b%b want 11", ok1, ok2); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", got.size()); end
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL basic_flit%0d got %h want %h", i, got[i], exp[i]); end
      end
      checks++; if (got_cyc[3] - got_cyc[0] != 3) begin errors++; $display("FAIL basic_spacing got %0d want 3", got_cyc[3] - got_cyc[0]); end
      checks++; if (sent_cyc.size() != 1) begin errors++; $display("FAIL basic_pkt_sent_count got %0d want 1", sent_cyc.size()); end
      else begin
        checks++; if (sent_cyc[0] != got_cyc[3] + 1) begin errors++; $display("FAIL basic_pkt_sent_cycle got %0d want %0d", sent_cyc[0], got_cyc[3] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2;
    logic [47:0] exp [4];
    clear_logs();
    words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
    exp[0] = head_f(2'd2, 6'd2); exp[1] = body_f(6'd0, words[0]);
    exp[2] = body_f(6'd1, words[1]); exp[3] = tail_f(2);
    fork
      drive_packet(2'd2, 6'd2, 2, ok1);
      begin
        int k;
        logic [47:0] held;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(flit_valid && flit_out[47:42] == 6'b101111) && k < 50);
        held = flit_out; full = 1'b1;
        repeat (4) begin
          @(negedge clk);
          checks++; if (flit_out !== held || flit_valid !== 1'b1) begin errors++; $display("FAIL bp_head_hold got %h want %h", flit_out, held); end
          checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL bp_full_data_ready got %b want 0", data_ready); end
          @(posedge clk); #1;
        end
        full = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(flit_valid && flit_out[47:40] == 8'h00) && k < 50);
        held = flit_out; do_not_send = 1'b1;
        repeat (2) begin
          @(negedge clk);
          checks++; if (flit_out !== held || flit_valid !== 1'b1) begin errors++; $display("FAIL bp_body_hold got %h want %h", flit_out, held); end
          checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL bp_dns_data_ready got %b want 0", data_ready); end
          @(posedge clk); #1;
        end
        do_not_send = 1'b0;
      end
    join
    wait_flits(4, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL bp_timeout got %b%b want 11", ok1, ok2); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got.size()); end
    if (got.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_flit%0d got %h want %h", i, got[i], exp[i]); end
      end
    end
    checks++; if (sent_cyc.size() != 1) begin errors++; $display("FAIL bp_pkt_sent got %0d want 1", sent_cyc.size()); end
  endtask

  task automatic test_zero_len();
    bit ok1, ok2;
    int dr0;
    clear_logs();
    dr0 = dr_seen;
    drive_packet(2'd1, 6'd0, 0, ok1);
    wait_flits(2, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL zero_timeout got %b%b want 11", ok1, ok2); end
    checks++; if (got.size() != 2) begin errors++; $display("FAIL zero_count got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== head_f(2'd1, 6'd0)) begin errors++; $display("FAIL zero_head got %h want %h", got[0], head_f(2'd1, 6'd0)); end
      checks++; if (got[1] !== tail_f(0)) begin errors++; $display("FAIL zero_tail got %h want %h", got[1], tail_f(0)); end
      checks++; if (got_cyc[1] != got_cyc[0] + 1) begin errors++; $display("FAIL zero_spacing got %0d want 1", got_cyc[1] - got_cyc[0]); end
    end
    checks++; if (dr_seen != dr0) begin errors++; $display("FAIL zero_data_ready got %0d want 0", dr_seen - dr0); end
  endtask

  task automatic test_clamp_back_to_back();
    bit ok1, ok2, r, tail_now;
    int k, c0;
    logic [47:0] exp [8];
    clear_logs();
    words[0] = 32'hA0000001; words[1] = 32'h0B00000B; words[2] = 32'h00C0C000; words[3] = 32'h55AA33CC;
    exp[0] = head_f(2'd0, 6'd4);
    for (int i = 0; i < 4; i++) exp[i+1] = body_f(6'(i), words[i]);
    exp[5] = tail_f(4); exp[6] = head_f(2'd3, 6'd0); exp[7] = tail_f(0);
    c0 = consumed;
    drive_packet(2'd0, 6'd9, 4, ok1);
    data_valid = 1'b1; data_in = 32'hBAD0BAD0;
    msg_valid = 1'b1; msg_dest = 2'd3; msg_len = 6'd0;
    k = 0; tail_now = 1'b0;
    do begin
      @(negedge clk); r = msg_ready;
      if (r) tail_now = flit_valid && !full && !do_not_send && (flit_out[47:40] == 8'hFF);
      @(posedge clk); #1; k++;
    end while (!r && k < 100);
    msg_valid = 1'b0; data_valid = 1'b0;
    wait_flits(8, ok2);
    checks++; if (!(ok1 && ok2 && r)) begin errors++; $display("FAIL clamp_timeout got %b%b%b want 111", ok1, ok2, r); end
    checks++; if (!tail_now) begin errors++; $display("FAIL clamp_hdr_at_tail got %b want 1", tail_now); end
    checks++; if (consumed - c0 != 4) begin errors++; $display("FAIL clamp_words_taken got %0d want 4", consumed - c0); end
    checks++; if (got.size() != 8) begin errors++; $display("FAIL clamp_count got %0d want 8", got.size()); end
    if (got.size() == 8) begin
      checks++; if (got[0][37:32] !== 6'd4) begin errors++; $display("FAIL clamp_len_field got %0d want 4", got[0][37:32]); end
      for (int i = 0; i < 8; i++) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL clamp_flit%0d got %h want %h", i, got[i], exp[i]); end
      end
      checks++; if (hdr_cyc.size() != 2) begin errors++; $display("FAIL clamp_hdr_count got %0d want 2", hdr_cyc.size()); end
      else begin
        checks++; if (hdr_cyc[1] != got_cyc[5]) begin errors++; $display("FAIL clamp_hdr_cycle got %0d want %0d", hdr_cyc[1], got_cyc[5]); end
      end
    end
    checks++; if (sent_cyc.size() != 2) begin errors++; $display("FAIL clamp_pkt_sent got %0d want 2", sent_cyc.size()); end
  endtask

  task automatic test_reset_mid_packet();
    bit r;
    int k;
    clear_logs();
    full = 1'b1;
    msg_valid = 1'b1; msg_dest = 2'd1; msg_len = 6'd2;
    k = 0;
    do begin @(negedge clk); r = msg_ready; @(posedge clk); #1; k++; end while (!r && k < 100);
    msg_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (flit_valid !== 1'b1) begin errors++; $display("FAIL mid_head_pending got %b want 1", flit_valid); end
    rst = 1'b0; #1;
    checks++; if (flit_valid !== 1'b0 || busy !== 1'b0 || flit_out !== 48'd0)
      begin errors++; $display("FAIL mid_reset got v=%b b=%b f=%h want 0", flit_valid, busy, flit_out); end
    @(posedge clk); #1;
    rst = 1'b1; full = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (got.size() != 0 || sent_cyc.size() != 0)
      begin errors++; $display("FAIL mid_abandon got flits=%0d sent=%0d want 0", got.size(), sent_cyc.size()); end
  endtask

`ifdef TX_CHECKSUM_EN
  task automatic test_checksum();
    bit ok1, ok2;
    clear_logs();
    words[0] = 32'h01020304; words[1] = 32'h10000000;
    drive_packet(2'd2, 6'd2, 2, ok1);
    wait_flits(4, ok2);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL csum_timeout got %b%b want 11", ok1, ok2); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL csum_count got %0d want 4", got.size()); end
    if (got.size() == 4) begin
      checks++; if (got[3] !== 48'hFF14_0000_0002) begin errors++; $display("FAIL csum_tail got %h want ff1400000002", got[3]); end
      checks++; if (got[0][31] !== 1'b1) begin errors++; $display("FAIL csum_head_flag got %b want 1", got[0][31]); end
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; msg_valid = 1'b0; msg_dest = '0; msg_len = '0;
    data_valid = 1'b0; data_in = '0; full = 1'b0; do_not_send = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_clamp_back_to_back();
    test_reset_mid_packet();
`ifdef TX_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
